id_ex_stage_reg: RTL and testbench

ID_EX_STAGE_REG -- requirements
Module: id_ex_stage_reg

---
 rtl/mips_pkg.sv | 43 ++++
 rtl/load_use_detect.sv | 20 ++
 rtl/id_ex_stage_reg.sv | 144 ++++++++++++++
 tb/tb_id_ex_stage_reg.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants: instruction field positions, ctrl-bus bit
// indices and ALU operation-class codes used by the ID/EX pipeline register.
package mips_pkg;

    localparam int OPCODE_MSB = 31;
    localparam int OPCODE_LSB = 26;
    localparam int RS_MSB     = 25;
    localparam int RS_LSB     = 21;
    localparam int RT_MSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_MSB     = 15;
    localparam int RD_LSB     = 11;
    localparam int SHAMT_MSB  = 10;
    localparam int SHAMT_LSB  = 6;
    localparam int FUNCT_MSB  = 5;
    localparam int FUNCT_LSB  = 0;
    localparam int IMM_MSB    = 15;
    localparam int IMM_LSB    = 0;

    localparam int OPCODE_W   = 6;
    localparam int FUNCT_W    = 6;
    localparam int IMM_W      = 16;

    // i_ctrl = {alu_op_sel[1:0], zero_ext, alu_src, reg_dst, mem_read, mem_write, reg_write}
    localparam int CTRL_W          = 8;
    localparam int CTRL_REG_WRITE  = 0;
    localparam int CTRL_MEM_WRITE  = 1;
    localparam int CTRL_MEM_READ   = 2;
    localparam int CTRL_REG_DST    = 3;
    localparam int CTRL_ALU_SRC    = 4;
    localparam int CTRL_ZERO_EXT   = 5;
    localparam int CTRL_ALU_OP_LSB = 6;
    localparam int CTRL_ALU_OP_MSB = 7;

    localparam logic [OPCODE_W-1:0] OPCODE_SPECIAL = '0;

    typedef enum logic [1:0] {
        ALU_OP_R_IMM  = 2'b00,
        ALU_OP_MEM    = 2'b01,
        ALU_OP_BRANCH = 2'b10
    } alu_op_sel_e;

endpackage

// File: rtl/load_use_detect.sv
// Load-use hazard detector: flags when the load sitting in EX writes a register
// the instruction held in ID is about to read.
module load_use_detect #(
    parameter int NB_ADDR = 5
) (
    input  logic               i_ex_valid,
    input  logic               i_ex_mem_read,
    input  logic [NB_ADDR-1:0] i_ex_rt_addr,
    input  logic               i_id_valid,
    input  logic [NB_ADDR-1:0] i_id_rs_addr,
    input  logic [NB_ADDR-1:0] i_id_rt_addr,
    output logic               o_hazard
);

    // $zero never carries a dependency, so a load targeting it is harmless.
    assign o_hazard = i_ex_valid & i_ex_mem_read & i_id_valid
                    & (i_ex_rt_addr != '0)
                    & ((i_ex_rt_addr == i_id_rs_addr) | (i_ex_rt_addr == i_id_rt_addr));

endmodule

// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register: decodes the ID instruction word into EX operands and
// controls, with flush, stall and load-use bubble insertion.
module id_ex_stage_reg
    import mips_pkg::*;
#(
    parameter int NB_DATA        = 32,
    parameter int NB_ADDR        = 5,
    parameter int NB_CTRL_OPCODE = 6,
    parameter int NB_ALU_OP_SEL  = 2
) (
    input  logic                      i_clock,
    input  logic                      i_reset_n,
    input  logic                      i_valid,
    input  logic                      i_stall,
    input  logic                      i_flush,
    input  logic [NB_DATA-1:0]        i_instruction,
    input  logic [NB_DATA-1:0]        i_rs_data,
    input  logic [NB_DATA-1:0]        i_rt_data,
    input  logic [CTRL_W-1:0]         i_ctrl,
    output logic                      o_valid,
    output logic [NB_CTRL_OPCODE-1:0] o_ctrl_opcode,
    output logic [NB_ALU_OP_SEL-1:0]  o_operation,
    output logic [NB_DATA-1:0]        o_rs_data,
    output logic [NB_DATA-1:0]        o_rt_data,
    output logic [NB_DATA-1:0]        o_imm,
    output logic [NB_ADDR-1:0]        o_shamt,
    output logic [NB_ADDR-1:0]        o_rs_addr,
    output logic [NB_ADDR-1:0]        o_rt_addr,
    output logic [NB_ADDR-1:0]        o_write_addr,
    output logic                      o_alu_src,
    output logic                      o_mem_read,
    output logic                      o_mem_write,
    output logic                      o_reg_write,
    output logic                      o_load_use_hazard
);

    logic [NB_ADDR-1:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
    logic [OPCODE_W-1:0] id_opcode;
    logic [FUNCT_W-1:0]  id_funct;
    logic [IMM_W-1:0]    id_imm16;
    logic                load_bubble;
    logic                load_en;

    logic                      d_valid;
    logic [NB_CTRL_OPCODE-1:0] d_ctrl_opcode;
    logic [NB_ALU_OP_SEL-1:0]  d_operation;
    logic [NB_DATA-1:0]        d_rs_data, d_rt_data, d_imm;
    logic [NB_ADDR-1:0]        d_shamt, d_rs_addr, d_rt_addr, d_write_addr;
    logic                      d_alu_src, d_mem_read, d_mem_write, d_reg_write;

    assign id_opcode  = i_instruction[OPCODE_MSB:OPCODE_LSB];
    assign id_funct   = i_instruction[FUNCT_MSB:FUNCT_LSB];
    assign id_imm16   = i_instruction[IMM_MSB:IMM_LSB];
    assign id_rs_addr = NB_ADDR'(i_instruction[RS_MSB:RS_LSB]);
    assign id_rt_addr = NB_ADDR'(i_instruction[RT_MSB:RT_LSB]);
    assign id_rd_addr = NB_ADDR'(i_instruction[RD_MSB:RD_LSB]);
    assign id_shamt   = NB_ADDR'(i_instruction[SHAMT_MSB:SHAMT_LSB]);

    load_use_detect #(
        .NB_ADDR (NB_ADDR)
    ) u_load_use_detect (
        .i_ex_valid    (o_valid),
        .i_ex_mem_read (o_mem_read),
        .i_ex_rt_addr  (o_rt_addr),
        .i_id_valid    (i_valid),
        .i_id_rs_addr  (id_rs_addr),
        .i_id_rt_addr  (id_rt_addr),
        .o_hazard      (o_load_use_hazard)
    );

    // Flush overrides stall, so a flushed edge always loads even when stalled.
    assign load_bubble = i_flush | o_load_use_hazard;
    assign load_en     = i_flush | ~i_stall;

    always_comb begin
        d_valid       = 1'b0;
        d_ctrl_opcode = '0;
        d_operation   = '0;
        d_rs_data     = '0;
        d_rt_data     = '0;
        d_imm         = '0;
        d_shamt       = '0;
        d_rs_addr     = '0;
        d_rt_addr     = '0;
        d_write_addr  = '0;
        d_alu_src     = 1'b0;
        d_mem_read    = 1'b0;
        d_mem_write   = 1'b0;
        d_reg_write   = 1'b0;
        if (!load_bubble) begin
            d_valid       = i_valid;
            d_ctrl_opcode = (id_opcode == OPCODE_SPECIAL) ? NB_CTRL_OPCODE'(id_funct)
                                                          : NB_CTRL_OPCODE'(id_opcode);
            d_operation   = NB_ALU_OP_SEL'(i_ctrl[CTRL_ALU_OP_MSB:CTRL_ALU_OP_LSB]);
            d_rs_data     = i_rs_data;
            d_rt_data     = i_rt_data;
            d_imm         = i_ctrl[CTRL_ZERO_EXT] ? NB_DATA'(id_imm16)
                                                  : {{(NB_DATA-IMM_W){id_imm16[IMM_W-1]}}, id_imm16};
            d_shamt       = id_shamt;
            d_rs_addr     = id_rs_addr;
            d_rt_addr     = id_rt_addr;
            d_write_addr  = i_ctrl[CTRL_REG_DST] ? id_rd_addr : id_rt_addr;
            d_alu_src     = i_ctrl[CTRL_ALU_SRC];
            d_mem_read    = i_valid & i_ctrl[CTRL_MEM_READ];
            d_mem_write   = i_valid & i_ctrl[CTRL_MEM_WRITE];
            d_reg_write   = i_valid & i_ctrl[CTRL_REG_WRITE];
        end
    end

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid       <= 1'b0;
            o_ctrl_opcode <= '0;
            o_operation   <= '0;
            o_rs_data     <= '0;
            o_rt_data     <= '0;
            o_imm         <= '0;
            o_shamt       <= '0;
            o_rs_addr     <= '0;
            o_rt_addr     <= '0;
            o_write_addr  <= '0;
            o_alu_src     <= 1'b0;
            o_mem_read    <= 1'b0;
            o_mem_write   <= 1'b0;
            o_reg_write   <= 1'b0;
        end else if (load_en) begin
            o_valid       <= d_valid;
            o_ctrl_opcode <= d_ctrl_opcode;
            o_operation   <= d_operation;
            o_rs_data     <= d_rs_data;
            o_rt_data     <= d_rt_data;
            o_imm         <= d_imm;
            o_shamt       <= d_shamt;
            o_rs_addr     <= d_rs_addr;
            o_rt_addr     <= d_rt_addr;
            o_write_addr  <= d_write_addr;
            o_alu_src     <= d_alu_src;
            o_mem_read    <= d_mem_read;
            o_mem_write   <= d_mem_write;
            o_reg_write   <= d_reg_write;
        end
    end

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// Scoreboard bench for id_ex_stage_reg: directed MIPS scenarios plus random
// traffic, checked against a field-decoding reference model.
module tb_id_ex_stage_reg;

    logic        clock;
    logic        reset_n;
    logic        valid, stall, flush;
    logic [31:0] instruction, rs_data_in, rt_data_in;
    logic [7:0]  ctrl;

    logic        out_valid;
    logic [5:0]  ctrl_opcode;
    logic [1:0]  operation;
    logic [31:0] out_rs_data, out_rt_data, imm;
    logic [4:0]  shamt, rs_addr, rt_addr, write_addr;
    logic        alu_src, mem_read, mem_write, reg_write, load_use_hazard;

    typedef struct packed {
        logic        valid;
        logic [5:0]  opcode;
        logic [1:0]  operation;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [4:0]  shamt;
        logic [4:0]  rs_addr;
        logic [4:0]  rt_addr;
        logic [4:0]  write_addr;
        logic        alu_src;
        logic        mem_read;
        logic        mem_write;
        logic        reg_write;
    } stage_t;

    typedef struct packed {
        stage_t s;
        logic   hz;
    } exp_t;

    exp_t   exp_q[$];
    stage_t model_state;
    int     total = 0;
    int     bad   = 0;

    id_ex_stage_reg #(
        .NB_DATA(32), .NB_ADDR(5), .NB_CTRL_OPCODE(6), .NB_ALU_OP_SEL(2)
    ) dut (
        .i_clock           (clock),
        .i_reset_n         (reset_n),
        .i_valid           (valid),
        .i_stall           (stall),
        .i_flush           (flush),
        .i_instruction     (instruction),
        .i_rs_data         (rs_data_in),
        .i_rt_data         (rt_data_in),
        .i_ctrl            (ctrl),
        .o_valid           (out_valid),
        .o_ctrl_opcode     (ctrl_opcode),
        .o_operation       (operation),
        .o_rs_data         (out_rs_data),
        .o_rt_data         (out_rt_data),
        .o_imm             (imm),
        .o_shamt           (shamt),
        .o_rs_addr         (rs_addr),
        .o_rt_addr         (rt_addr),
        .o_write_addr      (write_addr),
        .o_alu_src         (alu_src),
        .o_mem_read        (mem_read),
        .o_mem_write       (mem_write),
        .o_reg_write       (reg_write),
        .o_load_use_hazard (load_use_hazard)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Decodes an instruction the way the EX stage expects to see it.
    function automatic stage_t loadModel(input logic v, input logic [31:0] ins,
                                         input logic [31:0] rsd, input logic [31:0] rtd,
                                         input logic [7:0] c);
        stage_t      s;
        int unsigned op, funct, lo16;
        op    = ins >> 26;
        funct = ins % 64;
        lo16  = ins % 65536;
        s.valid      = v;
        s.opcode     = (op == 0) ? 6'(funct) : 6'(op);
        s.operation  = 2'(c / 64);
        s.rs_data    = rsd;
        s.rt_data    = rtd;
        if (c[5])
            s.imm = lo16;
        else
            s.imm = (lo16 >= 32768) ? lo16 + 32'hFFFF0000 : lo16;
        s.shamt      = 5'((ins >> 6) % 32);
        s.rs_addr    = 5'((ins >> 21) % 32);
        s.rt_addr    = 5'((ins >> 16) % 32);
        s.write_addr = c[3] ? 5'((ins >> 11) % 32) : s.rt_addr;
        s.alu_src    = c[4];
        s.mem_read   = v & c[2];
        s.mem_write  = v & c[1];
        s.reg_write  = v & c[0];
        return s;
    endfunction

    function automatic logic hazardModel(input stage_t s, input logic v, input logic [31:0] ins);
        int unsigned rs_f, rt_f;
        rs_f = (ins >> 21) % 32;
        rt_f = (ins >> 16) % 32;
        return s.valid && s.mem_read && v && (s.rt_addr != 0)
               && ((32'(s.rt_addr) == rs_f) || (32'(s.rt_addr) == rt_f));
    endfunction

    task automatic checkField(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("o_valid",           32'(out_valid),       32'(e.s.valid));
        checkField("o_ctrl_opcode",     32'(ctrl_opcode),     32'(e.s.opcode));
        checkField("o_operation",       32'(operation),       32'(e.s.operation));
        checkField("o_rs_data",         out_rs_data,          e.s.rs_data);
        checkField("o_rt_data",         out_rt_data,          e.s.rt_data);
        checkField("o_imm",             imm,                  e.s.imm);
        checkField("o_shamt",           32'(shamt),           32'(e.s.shamt));
        checkField("o_rs_addr",         32'(rs_addr),         32'(e.s.rs_addr));
        checkField("o_rt_addr",         32'(rt_addr),         32'(e.s.rt_addr));
        checkField("o_write_addr",      32'(write_addr),      32'(e.s.write_addr));
        checkField("o_alu_src",         32'(alu_src),         32'(e.s.alu_src));
        checkField("o_mem_read",        32'(mem_read),        32'(e.s.mem_read));
        checkField("o_mem_write",       32'(mem_write),       32'(e.s.mem_write));
        checkField("o_reg_write",       32'(reg_write),       32'(e.s.reg_write));
        checkField("o_load_use_hazard", 32'(load_use_hazard), 32'(e.hz));
    endtask

    // Drives one ID-stage cycle; the record pushed is what the DUT must show
    // before the coming edge, and the model then advances across that edge.
    task automatic applyStimulus(input logic v, input logic st, input logic fl,
                                 input logic [31:0] ins, input logic [31:0] rsd,
                                 input logic [31:0] rtd, input logic [7:0] c);
        exp_t e;
        valid       = v;
        stall       = st;
        flush       = fl;
        instruction = ins;
        rs_data_in  = rsd;
        rt_data_in  = rtd;
        ctrl        = c;
        e.s  = model_state;
        e.hz = hazardModel(model_state, v, ins);
        exp_q.push_back(e);
        if (fl)
            model_state = '0;
        else if (!st) begin
            if (e.hz)
                model_state = '0;
            else
                model_state = loadModel(v, ins, rsd, rtd, c);
        end
        @(posedge clock);
        #1;
    endtask

    // Reset is asserted mid-cycle, so the pushed all-zero record is checked
    // before any further clock edge.
    task automatic applyReset();
        exp_t e;
        reset_n = 1'b0;
        model_state = '0;
        e.s  = '0;
        e.hz = 1'b0;
        exp_q.push_back(e);
        @(posedge clock);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic applyRandom();
        logic [31:0] ins;
        ins = $urandom;
        if ($urandom_range(0, 1) == 1) ins[31:26] = 6'd0;
        ins[25:21] = 5'($urandom_range(0, 3));
        ins[20:16] = 5'($urandom_range(0, 3));
        applyStimulus($urandom_range(0, 3) != 0, $urandom_range(0, 5) == 0,
                      $urandom_range(0, 7) == 0, ins, $urandom, $urandom, 8'($urandom));
    endtask

    initial begin
        forever begin
            @(negedge clock);
            if (exp_q.size() > 0) checkOutput(exp_q.pop_front());
        end
    end

    initial begin
        reset_n = 1'b0;
        {valid, stall, flush} = 3'b000;
        instruction = '0;
        rs_data_in  = '0;
        rt_data_in  = '0;
        ctrl        = '0;
        model_state = '0;
        @(posedge clock);
        #1;
        applyReset();

        // add $3,$1,$2 then async reset while it sits in EX
        applyStimulus(1, 0, 0, 32'h00221820, 32'h11111111, 32'h22222222, 8'h09);
        applyStimulus(1, 0, 0, 32'h00221820, 32'h11111111, 32'h22222222, 8'h09);
        applyReset();

        // lw $5,-4($1) followed by dependent add $6,$5,$2 held for the bubble
        applyStimulus(1, 0, 0, 32'h8C25FFFC, 32'h00001000, 32'h0, 8'h55);
        applyStimulus(1, 0, 0, 32'h00A23020, 32'h0000AAAA, 32'h0000BBBB, 8'h09);
        applyStimulus(1, 0, 0, 32'h00A23020, 32'h0000AAAA, 32'h0000BBBB, 8'h09);

        // andi / addi immediate extension, then stall with changing inputs
        applyStimulus(1, 0, 0, 32'h30248000, 32'h00000123, 32'h0, 8'h31);
        applyStimulus(1, 0, 0, 32'h20248000, 32'h00000123, 32'h0, 8'h11);
        for (int i = 0; i < 3; i++)
            applyStimulus(1, 1, 0, $urandom, $urandom, $urandom, 8'($urandom));
        applyStimulus(1, 1, 1, 32'h00221820, 32'h5, 32'h6, 8'h09);

        // invalid slot with reg_write requested
        applyStimulus(0, 0, 0, 32'h00221820, 32'h7, 32'h8, 8'h09);

        // reset in the middle of a stall, then a normal load right after release
        applyStimulus(1, 0, 0, 32'h8C25FFFC, 32'h9, 32'hA, 8'h55);
        applyStimulus(1, 1, 0, 32'h00221820, 32'h9, 32'hA, 8'h09);
        stall = 1'b0;
        applyReset();
        applyStimulus(1, 0, 0, 32'h00221820, 32'hC, 32'hD, 8'h09);

        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 49) == 0)
                applyReset();
            else
                applyRandom();
        end
        applyStimulus(0, 0, 0, 32'h0, 32'h0, 32'h0, 8'h00);

        for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clock);
        #1;
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("[TB] FAIL drain: got=%0d pending expected=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
